temporizador_regressivo_m: RTL and testbench
============================================

Name: temporizador_regressivo_m

Overview:
Loadable modulo-M down-counter (countdown timer) with start/pause/abort control and an end-of-count pulse. It is the count-down counterpart of the team's modulo-M up-counter, using the same M/N parameters and fim/meio semantics. It times drone control intervals such as motor-settle windows and sonar timeouts. A single FSM owns the count register; all outputs derive from registered state.

Parameters:
M, 1000, default reload value is M-1, giving a period of M ticks; must satisfy 2 <= M <= 2^N
N, 11, counter/limit width in bits

Ports:
clock  input  1  system clock; all state updates on rising edge
zera_n  input  1  reset, synchronous, active-low
para  input  1  abort: return to OCIOSO, Q<=0
carrega  input  1  load limite<=valor; honoured only in OCIOSO or TERMINADO
valor  input  N  new limit value (count runs valor..0)
inicia  input  1  start countdown from limite
pausa  input  1  level: hold count while high
conta  input  1  tick enable; decrement only when high
recarga_auto  input  1  at terminal count, reload and continue instead of stopping
Q  output  N  current count value
fim  output  1  Q==0 while in CONTANDO or PAUSADO
meio  output  1  Q==limite/2 (integer division) while in CONTANDO or PAUSADO
pulso_fim  output  1  one-cycle pulse on the tick that consumes Q==0
pronto  output  1  high in OCIOSO and TERMINADO (ready to accept carrega/inicia)

Behaviour:
- Reset (zera_n=0 at posedge): state OCIOSO, Q=0, limite=M-1, pulso_fim=0, pronto=1, fim=0, meio=0. zera_n overrides every other input, including mid-count.
- Input priority each edge: zera_n > para > carrega > inicia > pausa > conta.
- States: OCIOSO, CONTANDO, PAUSADO, TERMINADO. Encode as a 2-bit registered state.
- OCIOSO/TERMINADO:
  - carrega=1: limite<=valor, with valor==0 clamped to 1. Q unchanged.
  - inicia=1 (carrega=0): Q<=limite, go to CONTANDO.
  - carrega and inicia in the same cycle: load only. A start needs inicia on a later cycle.
- CONTANDO:
  - pausa=1: go to PAUSADO, Q held. Any conta in that cycle is ignored.
  - else if conta=1 and Q!=0: Q<=Q-1.
  - else if conta=1 and Q==0: pulso_fim<=1 for exactly one cycle.
    - recarga_auto=1: Q<=limite, stay in CONTANDO.
    - recarga_auto=0: go to TERMINADO, Q stays 0.
  - carrega and inicia are ignored.
- PAUSADO: pausa=0 returns to CONTANDO the next edge; no decrement occurs on that edge.
- para=1 in any state: OCIOSO, Q<=0, pulso_fim<=0, limite retained.
- Latency: inicia at edge k gives Q=limite after k. With conta held high, pulso_fim is high in the cycle after edge k+limite+1. That is limite+1 ticks per period, so M ticks at default.
- pulso_fim is registered and cleared on every edge where it is not re-asserted.
- fim, meio and pronto are combinational decodes of state, Q and limite only; they have no path from inputs.
- Arithmetic: no underflow. Q==0 is detected before decrementing, and Q never wraps to 2^N-1.

Decomposition:
- Shared package (temporizador_pkg): state encodings OCIOSO=2'b00, CONTANDO=2'b01, PAUSADO=2'b10, TERMINADO=2'b11.
- The package is also reused by the future sonar timeout controller.
- One sub-module is natural: temporizador_fsm (next-state plus control strobes: load_q, dec_q, reload_q, clr_q, pulso).
- The datapath (Q, limite, decodes) stays in the top module.

Test Plan:
- Reset/default (M=10, N=4): zera_n=0 for 2 cycles, then inicia with conta=1. Required: Q sequence 9,8,...,0; meio=1 at Q=4; fim=1 at Q=0; one pulso_fim; state TERMINADO; pronto=1.
- Load/auto-reload: carrega with valor=3, then inicia with recarga_auto=1 and conta=1 for 12 cycles. Required: Q sequence 3,2,1,0,3,2,1,0,3,... and pulso_fim every 4th tick (3 pulses); pronto stays 0.
- Pause/tick gating: start from 9, toggle conta 1/0, and assert pausa for 3 cycles at Q=6. Required: Q held at 6 throughout the pause; no decrement on the release edge; resumes 5,4,...; total ticks to pulso_fim=10.
- Mid-operation abort/reset: para at Q=5 gives Q=0 in OCIOSO with no pulso_fim. Repeat with zera_n=0 at Q=5: also restores limite to 9.
- Priority edges:
  - carrega and inicia together in OCIOSO: limite updated, state stays OCIOSO.
  - carrega with valor=0: limite=1.
  - carrega during CONTANDO: ignored, limite unchanged.

Source files
------------

// File: rtl/temporizador_pkg.sv
// rtl/temporizador_pkg.sv - shared state encoding for countdown timers
package temporizador_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'b00,
    CONTANDO  = 2'b01,
    PAUSADO   = 2'b10,
    TERMINADO = 2'b11
  } estado_t;

  // Count is live (decodes valid) only while running or paused
  function automatic logic em_contagem(input estado_t st);
    return (st == CONTANDO) || (st == PAUSADO);
  endfunction

  function automatic logic aceita_comando(input estado_t st);
    return (st == OCIOSO) || (st == TERMINADO);
  endfunction

endpackage

// File: rtl/temporizador_fsm.sv
// rtl/temporizador_fsm.sv - countdown control FSM producing datapath strobes
module temporizador_fsm
  import temporizador_pkg::*;
(
  input  logic    clock,
  input  logic    zera_n,
  input  logic    para,
  input  logic    carrega,
  input  logic    inicia,
  input  logic    pausa,
  input  logic    conta,
  input  logic    recarga_auto,
  input  logic    q_zero,
  output estado_t estado,
  output logic    load_lim,
  output logic    load_q,
  output logic    dec_q,
  output logic    reload_q,
  output logic    clr_q,
  output logic    pulso
);

  estado_t estado_q, estado_d;

  always_ff @(posedge clock) begin
    if (!zera_n) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    load_lim = 1'b0;
    load_q   = 1'b0;
    dec_q    = 1'b0;
    reload_q = 1'b0;
    clr_q    = 1'b0;
    pulso    = 1'b0;

    if (para) begin
      clr_q    = 1'b1;
      estado_d = OCIOSO;
    end else begin
      unique case (estado_q)
        OCIOSO, TERMINADO: begin
          // A simultaneous carrega wins; inicia must come on a later cycle
          if (carrega) begin
            load_lim = 1'b1;
          end else if (inicia) begin
            load_q   = 1'b1;
            estado_d = CONTANDO;
          end
        end
        CONTANDO: begin
          if (pausa) begin
            estado_d = PAUSADO;
          end else if (conta) begin
            if (!q_zero) begin
              dec_q = 1'b1;
            end else begin
              pulso = 1'b1;
              if (recarga_auto) begin
                reload_q = 1'b1;
              end else begin
                estado_d = TERMINADO;
              end
            end
          end
        end
        PAUSADO: begin
          if (!pausa) begin
            estado_d = CONTANDO;
          end
        end
        default: estado_d = OCIOSO;
      endcase
    end
  end

  assign estado = estado_q;

endmodule

// File: rtl/temporizador_regressivo_m.sv
// rtl/temporizador_regressivo_m.sv - loadable modulo-M countdown timer
module temporizador_regressivo_m
  import temporizador_pkg::*;
#(
  parameter int M = 1000,
  parameter int N = 11
) (
  input  logic         clock,
  input  logic         zera_n,
  input  logic         para,
  input  logic         carrega,
  input  logic [N-1:0] valor,
  input  logic         inicia,
  input  logic         pausa,
  input  logic         conta,
  input  logic         recarga_auto,
  output logic [N-1:0] Q,
  output logic         fim,
  output logic         meio,
  output logic         pulso_fim,
  output logic         pronto
);

  localparam logic [N-1:0] LIMITE_RST = N'(M - 1);

  estado_t      estado;
  logic         load_lim, load_q, dec_q, reload_q, clr_q, pulso;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] limite_q, limite_d;
  logic         pulso_fim_q, pulso_fim_d;

  temporizador_fsm u_fsm (
    .clock        (clock),
    .zera_n       (zera_n),
    .para         (para),
    .carrega      (carrega),
    .inicia       (inicia),
    .pausa        (pausa),
    .conta        (conta),
    .recarga_auto (recarga_auto),
    .q_zero       (q_q == '0),
    .estado       (estado),
    .load_lim     (load_lim),
    .load_q       (load_q),
    .dec_q        (dec_q),
    .reload_q     (reload_q),
    .clr_q        (clr_q),
    .pulso        (pulso)
  );

  always_ff @(posedge clock) begin
    if (!zera_n) begin
      q_q         <= '0;
      limite_q    <= LIMITE_RST;
      pulso_fim_q <= 1'b0;
    end else begin
      q_q         <= q_d;
      limite_q    <= limite_d;
      pulso_fim_q <= pulso_fim_d;
    end
  end

  always_comb begin
    q_d = q_q;
    if (clr_q) begin
      q_d = '0;
    end else if (load_q || reload_q) begin
      q_d = limite_q;
    end else if (dec_q) begin
      q_d = q_q - N'(1);
    end
  end

  // A zero limit would make a degenerate single-tick period; clamp to 1
  always_comb begin
    limite_d = limite_q;
    if (load_lim) begin
      limite_d = (valor == '0) ? N'(1) : valor;
    end
  end

  assign pulso_fim_d = pulso;

  assign Q         = q_q;
  assign pulso_fim = pulso_fim_q;
  assign fim       = em_contagem(estado) && (q_q == '0);
  assign meio      = em_contagem(estado) && (q_q == (limite_q >> 1));
  assign pronto    = aceita_comando(estado);

endmodule

// File: tb/tb_temporizador_regressivo_m.sv
// tb/tb_temporizador_regressivo_m.sv - directed scoreboard bench for the countdown timer
module tb_temporizador_regressivo_m;

  localparam int M = 10;
  localparam int N = 4;

  typedef struct {
    logic [N-1:0] q;
    logic         fim;
    logic         meio;
    logic         pulso;
    logic         pronto;
  } esperado_t;

  logic         clock = 1'b0;
  logic         zera_n, para, carrega, inicia, pausa, conta, recarga_auto;
  logic [N-1:0] valor;
  logic [N-1:0] Q;
  logic         fim, meio, pulso_fim, pronto;

  esperado_t exp_q[$];
  string     tag_q[$];
  int        checks   = 0;
  int        failures = 0;

  temporizador_regressivo_m #(.M(M), .N(N)) dut (
    .clock        (clock),
    .zera_n       (zera_n),
    .para         (para),
    .carrega      (carrega),
    .valor        (valor),
    .inicia       (inicia),
    .pausa        (pausa),
    .conta        (conta),
    .recarga_auto (recarga_auto),
    .Q            (Q),
    .fim          (fim),
    .meio         (meio),
    .pulso_fim    (pulso_fim),
    .pronto       (pronto)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Push expectation, clock one edge, then pop and compare 1ns after the edge
  task automatic step(input string tag, input int q, input bit f, input bit m,
                      input bit p, input bit r);
    esperado_t e;
    esperado_t got;
    string     t;
    e.q = N'(q); e.fim = f; e.meio = m; e.pulso = p; e.pronto = r;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    got = exp_q.pop_front();
    t   = tag_q.pop_front();
    chk({t, ".Q"},         8'(Q),     8'(got.q));
    chk({t, ".fim"},       8'(fim),   8'(got.fim));
    chk({t, ".meio"},      8'(meio),  8'(got.meio));
    chk({t, ".pulso_fim"}, 8'(pulso_fim), 8'(got.pulso));
    chk({t, ".pronto"},    8'(pronto), 8'(got.pronto));
  endtask

  initial begin
    zera_n = 1'b0; para = 1'b0; carrega = 1'b0; inicia = 1'b0;
    pausa = 1'b0; conta = 1'b0; recarga_auto = 1'b0; valor = '0;
    #2;

    // Reset and default period of M ticks
    step("reset0", 0, 0, 0, 0, 1);
    step("reset1", 0, 0, 0, 0, 1);
    zera_n = 1'b1; inicia = 1'b1; conta = 1'b1;
    step("def_start", 9, 0, 0, 0, 0);
    inicia = 1'b0;
    for (int v = 8; v >= 0; v--) step("def_count", v, v == 0, v == 4, 0, 0);
    step("def_pulse", 0, 0, 0, 1, 1);
    conta = 1'b0;
    step("def_done", 0, 0, 0, 0, 1);

    // Load 3 and auto-reload: pulse every 4th tick
    carrega = 1'b1; valor = 4'd3;
    step("load3", 0, 0, 0, 0, 1);
    carrega = 1'b0; inicia = 1'b1; recarga_auto = 1'b1; conta = 1'b1;
    step("auto_start", 3, 0, 0, 0, 0);
    inicia = 1'b0;
    for (int i = 0; i < 12; i++) begin
      int v;
      v = (i % 4 == 3) ? 3 : 2 - (i % 4);
      step("auto_count", v, v == 0, v == 1, i % 4 == 3, 0);
    end
    para = 1'b1;
    step("auto_abort", 0, 0, 0, 0, 1);
    para = 1'b0; recarga_auto = 1'b0; conta = 1'b0;

    // carrega and inicia together: load only
    carrega = 1'b1; inicia = 1'b1; valor = 4'd9;
    step("ld_and_start", 0, 0, 0, 0, 1);
    carrega = 1'b0;
    step("start9", 9, 0, 0, 0, 0);
    inicia = 1'b0;

    // Tick gating and pause at Q=6
    conta = 1'b1; step("gate_a", 8, 0, 0, 0, 0);
    conta = 1'b0; step("gate_b", 8, 0, 0, 0, 0);
    conta = 1'b1; step("gate_c", 7, 0, 0, 0, 0);
    conta = 1'b0; step("gate_d", 7, 0, 0, 0, 0);
    conta = 1'b1; step("gate_e", 6, 0, 0, 0, 0);
    pausa = 1'b1;
    for (int i = 0; i < 3; i++) step("paused", 6, 0, 0, 0, 0);
    pausa = 1'b0;
    step("release", 6, 0, 0, 0, 0);
    for (int v = 5; v >= 0; v--) step("resume", v, v == 0, v == 4, 0, 0);
    step("pause_pulse", 0, 0, 0, 1, 1);

    // Abort with para at Q=5
    conta = 1'b0; inicia = 1'b1;
    step("ab_start", 9, 0, 0, 0, 0);
    inicia = 1'b0; conta = 1'b1;
    for (int v = 8; v >= 5; v--) step("ab_count", v, 0, v == 4, 0, 0);
    para = 1'b1;
    step("ab_para", 0, 0, 0, 0, 1);
    para = 1'b0;
    step("ab_idle", 0, 0, 0, 0, 1);

    // carrega ignored while counting: reload value proves limite kept 7
    conta = 1'b0; carrega = 1'b1; valor = 4'd7;
    step("load7", 0, 0, 0, 0, 1);
    carrega = 1'b0; inicia = 1'b1;
    step("start7", 7, 0, 0, 0, 0);
    inicia = 1'b0; conta = 1'b1; carrega = 1'b1; valor = 4'd2;
    step("ld_in_count", 6, 0, 0, 0, 0);
    carrega = 1'b0;
    for (int v = 5; v >= 0; v--) step("cnt7", v, v == 0, v == 3, 0, 0);
    recarga_auto = 1'b1;
    step("reload7", 7, 0, 0, 1, 0);
    recarga_auto = 1'b0;

    // zera_n mid-count at Q=5 restores limite to M-1
    step("z_count6", 6, 0, 0, 0, 0);
    step("z_count5", 5, 0, 0, 0, 0);
    zera_n = 1'b0;
    step("z_reset", 0, 0, 0, 0, 1);
    zera_n = 1'b1; conta = 1'b0; inicia = 1'b1;
    step("z_start9", 9, 0, 0, 0, 0);
    inicia = 1'b0; para = 1'b1;
    step("z_para", 0, 0, 0, 0, 1);
    para = 1'b0;

    // valor=0 clamps limite to 1
    carrega = 1'b1; valor = 4'd0;
    step("load0", 0, 0, 0, 0, 1);
    carrega = 1'b0; inicia = 1'b1;
    step("start1", 1, 0, 0, 0, 0);
    inicia = 1'b0; conta = 1'b1;
    step("one_to_zero", 0, 1, 1, 0, 0);
    step("one_pulse", 0, 0, 0, 1, 1);
    conta = 1'b0;
    step("one_done", 0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
